// File: rtl/neogeo_bus_pkg.sv
// Shared bus types and constants for the 68k bus bridge.
package neogeo_bus_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned CNT_W  = 8;

  // Value presented on FX68K_DATAIN when no device drives the bus.
  localparam logic [DATA_W-1:0] IDLE_BUS_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } bus_state_e;

  // Request latched toward the fabric at the start of a 68k bus cycle.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/m68k_wait_counter.sv
// Enable-gated wait-state counter for the 68k bus bridge.
// Compare outputs refer to the count including the enable being sampled.
// The ==TIMEOUT compare exists only when M68K_BUS_TIMEOUT_EN is defined.
module m68k_wait_counter
  import neogeo_bus_pkg::*;
#(
  parameter int unsigned MIN_WAIT = 2,
`ifdef M68K_BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT  = 255,
`endif
  parameter int unsigned SAT_MAX  = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
`ifdef M68K_BUS_TIMEOUT_EN
  output logic eq_timeout_c,
`endif
  output logic ge_min_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);

  // Clear on issue, otherwise saturating increment on each enable
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_W'(SAT_MAX))) begin
      count_d = count_inc[CNT_W-1:0];
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ge_min_c = (count_inc >= (CNT_W+1)'(MIN_WAIT));
`ifdef M68K_BUS_TIMEOUT_EN
  assign eq_timeout_c = (count_inc == (CNT_W+1)'(TIMEOUT));
`endif

endmodule

// File: rtl/m68k_bus_bridge.sv
// 68000 bus cycle to single-beat req/ack bridge with minimum wait states.
// Optional bus timeout enabled by defining M68K_BUS_TIMEOUT_EN.
module m68k_bus_bridge
  import neogeo_bus_pkg::*;
#(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLK_EN_68K_P,
  input  logic              nAS,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic              M68K_RW,
  input  logic [ADDR_W-1:0] M68K_ADDR,
  input  logic [DATA_W-1:0] FX68K_DATAOUT,
  output logic              nDTACK,
  output logic [DATA_W-1:0] FX68K_DATAIN,
  output logic              REQ,
  output logic [ADDR_W-1:0] REQ_ADDR,
  output logic              REQ_WE,
  output logic [BE_W-1:0]   REQ_BE,
  output logic [DATA_W-1:0] REQ_WDATA,
  input  logic              ACK,
  input  logic [DATA_W-1:0] ACK_DATA,
  output logic              TIMEOUT_ERR
);

  // Counter only needs to reach whichever compare point is larger.
  localparam int unsigned SAT_MAX = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;

  bus_state_e        state_q, state_d;
  bus_req_t          req_pl_q, req_pl_d;
  logic              req_q, req_d;
  logic              ndtack_q, ndtack_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic in_cycle_c, start_c, ack_c, abort_now_c;
  logic hold_c, release_c, timeout_c, ge_min_c;

  assign in_cycle_c  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign start_c     = (state_q == ST_IDLE) && CLK_EN_68K_P && !nAS && (!nUDS || !nLDS);
  assign ack_c       = in_cycle_c && req_q && ACK;
  // CPU has dropped nAS before we acknowledged: finish the fabric side silently.
  assign abort_now_c = abort_q || (CLK_EN_68K_P && nAS);
  assign release_c   = in_cycle_c && ((ack_c && abort_now_c) || (CLK_EN_68K_P && nAS && done_q));
  assign hold_c      = in_cycle_c && CLK_EN_68K_P && !nAS && !abort_q && done_q && ge_min_c;

`ifdef M68K_BUS_TIMEOUT_EN
  logic terr_q, terr_d;
  logic eq_timeout_c;

  assign timeout_c   = in_cycle_c && CLK_EN_68K_P && eq_timeout_c && req_q && !ack_c;
  assign TIMEOUT_ERR = terr_q;
`else
  assign timeout_c   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  m68k_wait_counter #(
    .MIN_WAIT     (MIN_WAIT),
`ifdef M68K_BUS_TIMEOUT_EN
    .TIMEOUT      (TIMEOUT),
`endif
    .SAT_MAX      (SAT_MAX)
  ) u_wait_counter (
    .clk          (CLK),
    .rst          (RESET),
    .clr          (start_c),
    .inc          (in_cycle_c && CLK_EN_68K_P),
`ifdef M68K_BUS_TIMEOUT_EN
    .eq_timeout_c (eq_timeout_c),
`endif
    .ge_min_c     (ge_min_c)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_c) state_d = ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (release_c || (timeout_c && abort_now_c)) begin
          state_d = ST_RELEASE;
        end else if (hold_c || timeout_c) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (CLK_EN_68K_P && nAS) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    req_d    = req_q;
    req_pl_d = req_pl_q;
    ndtack_d = ndtack_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    abort_d  = abort_q;
`ifdef M68K_BUS_TIMEOUT_EN
    terr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          req_d          = 1'b1;
          req_pl_d.addr  = M68K_ADDR;
          req_pl_d.we    = ~M68K_RW;
          req_pl_d.be    = {~nUDS, ~nLDS};
          req_pl_d.wdata = FX68K_DATAOUT;
          done_d         = 1'b0;
          abort_d        = 1'b0;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        abort_d = abort_now_c;
        if (ack_c) begin
          req_d  = 1'b0;
          done_d = 1'b1;
          if (!abort_now_c && !req_pl_q.we) rdata_d = ACK_DATA;
        end
        if (timeout_c) begin
          req_d = 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
          terr_d = 1'b1;
`endif
          if (!abort_now_c && !req_pl_q.we) rdata_d = IDLE_BUS_DATA;
        end
        if (hold_c || (timeout_c && !abort_now_c)) ndtack_d = 1'b0;
      end
      ST_HOLD: begin
        if (CLK_EN_68K_P && nAS) ndtack_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q    <= 1'b0;
      req_pl_q <= '0;
      ndtack_q <= 1'b1;
      rdata_q  <= IDLE_BUS_DATA;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
      terr_q   <= 1'b0;
`endif
    end else begin
      req_q    <= req_d;
      req_pl_q <= req_pl_d;
      ndtack_q <= ndtack_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
`ifdef M68K_BUS_TIMEOUT_EN
      terr_q   <= terr_d;
`endif
    end
  end

  assign nDTACK       = ndtack_q;
  assign FX68K_DATAIN = rdata_q;
  assign REQ          = req_q;
  assign REQ_ADDR     = req_pl_q.addr;
  assign REQ_WE       = req_pl_q.we;
  assign REQ_BE       = req_pl_q.be;
  assign REQ_WDATA    = req_pl_q.wdata;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Self-checking bench for m68k_bus_bridge (optionally built with M68K_BUS_TIMEOUT_EN).
module tb_m68k_bus_bridge;

  localparam int TB_MIN_WAIT = 2;
`ifdef M68K_BUS_TIMEOUT_EN
  localparam int TB_TIMEOUT  = 8;
  localparam int SLOW_EN     = 6;
`else
  localparam int TB_TIMEOUT  = 255;
  localparam int SLOW_EN     = 10;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CLK_EN_68K_P = 1'b0;
  logic        nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, M68K_RW = 1'b1;
  logic [22:0] M68K_ADDR = '0;
  logic [15:0] FX68K_DATAOUT = '0;
  logic        nDTACK;
  logic [15:0] FX68K_DATAIN;
  logic        REQ;
  logic [22:0] REQ_ADDR;
  logic        REQ_WE;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        ACK = 1'b0;
  logic [15:0] ACK_DATA = '0;
  logic        TIMEOUT_ERR;

  int          n_checks = 0;
  int          n_pass = 0;
  int          phase = 0;
  logic        en_seen = 1'b0;
  logic [15:0] exp_datain = 16'hFFFF;

  m68k_bus_bridge #(.MIN_WAIT(TB_MIN_WAIT), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_EN_68K_P(CLK_EN_68K_P),
    .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(M68K_RW),
    .M68K_ADDR(M68K_ADDR), .FX68K_DATAOUT(FX68K_DATAOUT),
    .nDTACK(nDTACK), .FX68K_DATAIN(FX68K_DATAIN),
    .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_WE(REQ_WE), .REQ_BE(REQ_BE),
    .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ACK_DATA(ACK_DATA),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock step; en_seen tells whether the DUT saw an enable at that edge.
  task automatic tick();
    en_seen = CLK_EN_68K_P;
    @(posedge CLK);
    #1;
    phase++;
    CLK_EN_68K_P = ((phase % 4) == 3);
  endtask

  task automatic wait_enable();
    int g = 0;
    do begin tick(); g++; end while (!en_seen && g < 20);
    n_checks++;
    if (en_seen !== 1'b1) $display("FAIL wait_enable: en=%b required 1", en_seen);
    else n_pass++;
  endtask

  task automatic start_cycle(input logic [22:0] addr, input logic rw, input logic [1:0] be,
                             input logic [15:0] wd, input bit late);
    int g;
    M68K_ADDR = addr; M68K_RW = rw; FX68K_DATAOUT = wd; nAS = 1'b0;
    if (late) begin
      nUDS = 1'b1; nLDS = 1'b1;
      wait_enable();
      tick(); tick();
      n_checks++;
      if (REQ !== 1'b0) $display("FAIL late_strobe_noreq: REQ=%b required 0", REQ);
      else n_pass++;
    end
    nUDS = ~be[1]; nLDS = ~be[0];
    g = 0;
    do begin tick(); g++; end while (REQ !== 1'b1 && g < 40);
    n_checks++;
    if (REQ !== 1'b1 || en_seen !== 1'b1)
      $display("FAIL issue: REQ=%b en=%b required 1/1", REQ, en_seen);
    else n_pass++;
    n_checks++;
    if ({REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA} !== {addr, ~rw, be, wd})
      $display("FAIL req_payload: addr=%h we=%b be=%b wd=%h required addr=%h we=%b be=%b wd=%h",
               REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA, addr, ~rw, be, wd);
    else n_pass++;
  endtask

  task automatic release_cycle(input int extra_en);
    bit ok = 1'b1;
    int g;
    for (int i = 0; i < extra_en; i++) begin
      g = 0;
      do begin tick(); g++; if (nDTACK !== 1'b0) ok = 1'b0; end while (!en_seen && g < 20);
    end
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    g = 0;
    do begin
      tick(); g++;
      if (!en_seen && nDTACK !== 1'b0) ok = 1'b0;
    end while (!en_seen && g < 20);
    n_checks++;
    if (!ok || nDTACK !== 1'b1 || en_seen !== 1'b1)
      $display("FAIL dtack_release: nDTACK=%b held_ok=%b required 1/1", nDTACK, ok);
    else n_pass++;
  endtask

  // Full cycle; nDTACK expected at enable max(MIN_WAIT, enables-up-to-ACK + 1).
  task automatic run_cycle(input string tag, input logic [22:0] addr, input logic rw,
                           input logic [1:0] be, input logic [15:0] wd, input logic [15:0] rd,
                           input int ack_clks, input bit late, input int extra_en);
    int en_cnt, k, g;
    bit ok;
    start_cycle(addr, rw, be, wd, late);
    en_cnt = 0; ok = 1'b1;
    for (int i = 0; i < ack_clks; i++) begin
      tick();
      if (en_seen) en_cnt++;
      if (REQ !== 1'b1 || nDTACK !== 1'b1 || TIMEOUT_ERR !== 1'b0) ok = 1'b0;
    end
    ACK = 1'b1; ACK_DATA = rd;
    tick();
    if (en_seen) en_cnt++;
    ACK = 1'b0; ACK_DATA = 16'($urandom);
    n_checks++;
    if (!ok || REQ !== 1'b0)
      $display("FAIL %s req_until_ack: REQ=%b held_ok=%b required 0/1", tag, REQ, ok);
    else n_pass++;
    k = (TB_MIN_WAIT > en_cnt + 1) ? TB_MIN_WAIT : en_cnt + 1;
    if (rw) exp_datain = rd;
    g = 0;
    while (nDTACK === 1'b1 && g < 400) begin
      tick(); g++;
      if (en_seen) en_cnt++;
      if (TIMEOUT_ERR !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (nDTACK !== 1'b0 || en_seen !== 1'b1 || en_cnt != k || !ok)
      $display("FAIL %s dtack_assert: nDTACK=%b at enable %0d required 0 at enable %0d",
               tag, nDTACK, en_cnt, k);
    else n_pass++;
    n_checks++;
    if (FX68K_DATAIN !== exp_datain)
      $display("FAIL %s datain: got %h required %h", tag, FX68K_DATAIN, exp_datain);
    else n_pass++;
    release_cycle(extra_en);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if ({nDTACK, FX68K_DATAIN, REQ, REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA, TIMEOUT_ERR} !==
        {1'b1, 16'hFFFF, 1'b0, 23'h0, 1'b0, 2'b00, 16'h0, 1'b0})
      $display("FAIL reset_values: dtack=%b din=%h req=%b addr=%h we=%b be=%b wd=%h terr=%b required 1/ffff/0/0/0/0/0/0",
               nDTACK, FX68K_DATAIN, REQ, REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA, TIMEOUT_ERR);
    else n_pass++;
    RESET = 1'b0;
    exp_datain = 16'hFFFF;
    tick();
  endtask

  task automatic test_basic_read();
    run_cycle("basic_read", 23'h000100, 1'b1, 2'b11, 16'h0000, 16'h1234, 1, 1'b0, 0);
  endtask

  task automatic test_slow_write();
    run_cycle("slow_write", 23'h00_4321, 1'b0, 2'b01, 16'h00AB, 16'hDEAD, SLOW_EN * 4, 1'b0, 1);
  endtask

  task automatic test_late_strobe();
    run_cycle("late_strobe", 23'h3F_0F0F, 1'b0, 2'b10, 16'hC300, 16'h0000, 2, 1'b1, 0);
  endtask

  task automatic test_abort();
    bit ok = 1'b1;
    int g;
    start_cycle(23'h0ABCDE, 1'b1, 2'b11, 16'h0000, 1'b0);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    for (int e = 0; e < 2; e++) begin
      g = 0;
      do begin tick(); g++; if (REQ !== 1'b1 || nDTACK !== 1'b1) ok = 1'b0; end
      while (!en_seen && g < 20);
    end
    tick();
    n_checks++;
    if (!ok || REQ !== 1'b1) $display("FAIL abort_req_held: REQ=%b held_ok=%b required 1/1", REQ, ok);
    else n_pass++;
    ACK = 1'b1; ACK_DATA = 16'h5A5A;
    tick();
    ACK = 1'b0;
    n_checks++;
    if (REQ !== 1'b0) $display("FAIL abort_ack_consumed: REQ=%b required 0", REQ);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (nDTACK !== 1'b1 || REQ !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL abort_no_dtack: nDTACK=%b REQ=%b required 1/0 throughout", nDTACK, REQ);
    else n_pass++;
    run_cycle("after_abort", 23'h000F00, 1'b1, 2'b11, 16'h0000, 16'h0F0F, 3, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b1;
    start_cycle(23'h012345, 1'b0, 2'b10, 16'hBEEF, 1'b0);
    tick(); tick(); tick();
    RESET = 1'b1; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    tick();
    n_checks++;
    if ({nDTACK, FX68K_DATAIN, REQ, REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA, TIMEOUT_ERR} !==
        {1'b1, 16'hFFFF, 1'b0, 23'h0, 1'b0, 2'b00, 16'h0, 1'b0})
      $display("FAIL reset_mid_values: dtack=%b din=%h req=%b addr=%h we=%b be=%b wd=%h required 1/ffff/0/0/0/0/0",
               nDTACK, FX68K_DATAIN, REQ, REQ_ADDR, REQ_WE, REQ_BE, REQ_WDATA);
    else n_pass++;
    RESET = 1'b0;
    exp_datain = 16'hFFFF;
    ACK = 1'b1; ACK_DATA = 16'h1111;
    tick();
    ACK = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (nDTACK !== 1'b1 || REQ !== 1'b0 || FX68K_DATAIN !== 16'hFFFF) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL stray_ack_ignored: nDTACK=%b REQ=%b din=%h required 1/0/ffff", nDTACK, REQ, FX68K_DATAIN);
    else n_pass++;
  endtask

`ifdef M68K_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int en_cnt = 0;
    int g = 0;
    start_cycle(23'h000200, 1'b1, 2'b11, 16'h0000, 1'b0);
    while (TIMEOUT_ERR !== 1'b1 && g < 200) begin
      tick(); g++;
      if (en_seen) en_cnt++;
    end
    n_checks++;
    if (TIMEOUT_ERR !== 1'b1 || en_cnt != TB_TIMEOUT || nDTACK !== 1'b0 ||
        FX68K_DATAIN !== 16'hFFFF || REQ !== 1'b0)
      $display("FAIL timeout_fire: terr=%b en=%0d dtack=%b din=%h req=%b required 1/%0d/0/ffff/0",
               TIMEOUT_ERR, en_cnt, nDTACK, FX68K_DATAIN, REQ, TB_TIMEOUT);
    else n_pass++;
    tick();
    n_checks++;
    if (TIMEOUT_ERR !== 1'b0) $display("FAIL timeout_pulse: terr=%b required 0", TIMEOUT_ERR);
    else n_pass++;
    ACK = 1'b1; ACK_DATA = 16'h7777;
    tick();
    ACK = 1'b0;
    tick();
    n_checks++;
    if (nDTACK !== 1'b0 || FX68K_DATAIN !== 16'hFFFF)
      $display("FAIL late_ack_ignored: dtack=%b din=%h required 0/ffff", nDTACK, FX68K_DATAIN);
    else n_pass++;
    exp_datain = 16'hFFFF;
    release_cycle(0);
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      run_cycle("random", 23'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
                16'($urandom), 16'($urandom), int'($urandom_range(0, 20)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_slow_write();
    test_late_strobe();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef M68K_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_basic_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/m68k_bus_bridge.md
Name: m68k_bus_bridge

Overview:
- Sits directly downstream of the 68000 core wrapper: consumes its asynchronous-style bus signals (nAS, nUDS, nLDS, M68K_RW, M68K_ADDR, FX68K_DATAOUT).
- Produces nDTACK and FX68K_DATAIN back to it.
- Converts each 68k bus cycle into a single-beat req/ack transaction toward the memory/IO fabric.
- Enforces a programmable minimum wait-state count and an optional bus-timeout.

Parameters:
- MIN_WAIT, 2, minimum CLK_EN_68K_P enables between request issue and nDTACK assertion (0..15).
- TIMEOUT, 255, enable count after which an unacknowledged request is force-completed (only with timeout feature).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- CLK_EN_68K_P  in  1  68k phase-1 clock enable; all bus-side sampling and nDTACK updates occur on it
- nAS  in  1  address strobe from CPU
- nUDS  in  1  upper data strobe
- nLDS  in  1  lower data strobe
- M68K_RW  in  1  1=read, 0=write
- M68K_ADDR  in  23  word address [23:1]
- FX68K_DATAOUT  in  16  CPU write data
- nDTACK  out  1  data acknowledge to CPU
- FX68K_DATAIN  out  16  registered read data to CPU
- REQ  out  1  request to fabric, level, held until ACK
- REQ_ADDR  out  23  latched address
- REQ_WE  out  1  1=write
- REQ_BE  out  2  byte enables {~nUDS,~nLDS}
- REQ_WDATA  out  16  latched write data
- ACK  in  1  one-CLK pulse from fabric completing REQ
- ACK_DATA  in  16  read data valid with ACK
- TIMEOUT_ERR  out  1  one-CLK pulse when a cycle is force-completed

Behaviour:
- Reset values: nDTACK=1, FX68K_DATAIN=16'hFFFF, REQ=0, REQ_ADDR=0, REQ_WE=0, REQ_BE=0, REQ_WDATA=0, TIMEOUT_ERR=0, state IDLE, counters 0.
- FSM states: IDLE, ISSUE, WAIT, HOLD, RELEASE.
- IDLE: on CLK_EN_68K_P with nAS=0 and (nUDS=0 or nLDS=0) -> latch ADDR, RW, BE, WDATA; REQ=1 next CLK; goto ISSUE. Cycles with both strobes high are not started (write strobes arrive one phase late; the bridge waits for them).
- ISSUE/WAIT: REQ held high until ACK sampled on any CLK. On ACK: REQ=0 same edge; read captures ACK_DATA into FX68K_DATAIN; flag done.
- The wait counter increments on each CLK_EN_68K_P from issue. Transition to HOLD at the first CLK_EN_68K_P where done=1 and count>=MIN_WAIT. nDTACK=0 from that edge. With MIN_WAIT=0 and ACK in the issue cycle, nDTACK asserts on the next enable.
- ACK while REQ=0 is ignored.
- HOLD: nDTACK held 0 until an enable samples nAS=1 -> nDTACK=1; goto IDLE via RELEASE (one CLK). Back-to-back cycles therefore need nAS high for at least one enable.
- nAS negated before ACK (CPU reset/abort): REQ stays high until ACK. That ACK is consumed silently; nDTACK never asserts; then return to IDLE.
- RESET mid-cycle: immediate return to reset values; a late ACK after reset is ignored.
- FX68K_DATAIN keeps its last value between cycles; writes do not modify it.

Optional Feature:
- Macro M68K_BUS_TIMEOUT_EN.
- Defined: a counter of CLK_EN_68K_P enables in ISSUE/WAIT. Reaching TIMEOUT forces REQ=0, FX68K_DATAIN=16'hFFFF (reads), TIMEOUT_ERR pulse, and goto HOLD. A late ACK for that request is ignored.
- Undefined: no counter; TIMEOUT_ERR tied 0; bridge waits indefinitely.

Decomposition:
- Shared package neogeo_bus_pkg: FSM state enum, BE width constant, IDLE_BUS_DATA=16'hFFFF.
- One natural sub-module: m68k_wait_counter (enable-gated counter with >=MIN_WAIT and ==TIMEOUT compare outputs).

Test Plan:
- Read, MIN_WAIT=2: ADDR=23'h000100, UDS/LDS low, ACK after 1 CLK with ACK_DATA=16'h1234 -> REQ_BE=2'b11, nDTACK low on 2nd enable after issue, FX68K_DATAIN=16'h1234, nDTACK high on first enable after nAS=1.
- Byte write, slow ack: nLDS=0, nUDS=1, DATAOUT=16'h00AB, ACK after 10 enables -> REQ_WE=1, REQ_BE=2'b01, REQ_WDATA=16'h00AB, nDTACK asserts on the enable after ACK.
- Late data strobe: nAS low one enable before nUDS/nLDS -> REQ not raised until strobes low; latched BE correct.
- Abort: nAS returns high before ACK -> REQ held until ACK, nDTACK stays 1, next cycle starts normally.
- RESET asserted in WAIT -> all outputs at reset values next CLK; subsequent stray ACK produces no nDTACK.
- With M68K_BUS_TIMEOUT_EN, TIMEOUT=8, no ACK -> after 8 enables TIMEOUT_ERR pulses, FX68K_DATAIN=16'hFFFF, nDTACK=0.
